// File: rtl/pipe_pkg.sv
// Shared types and widths for the ID/EX pipeline register slice.
package pipe_pkg;

  localparam int XLEN_P     = 32;
  localparam int VLANES_P   = 3;
  localparam int VELEM_W_P  = 16;
  localparam int VW_P       = VLANES_P * VELEM_W_P;
  localparam int ALU_CTRL_W = 5;
  localparam int REG_IDX_W  = 5;

  typedef struct packed {
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic [ALU_CTRL_W-1:0] alu_control;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [XLEN_P-1:0]    pc;
    logic [XLEN_P-1:0]    rd1;
    logic [XLEN_P-1:0]    rd2;
    logic [XLEN_P-1:0]    sign_imm;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] vd;
    logic [VW_P-1:0]      rd1v;
    logic [VW_P-1:0]      rd2v;
  } id_ex_data_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// One-entry skid buffer in front of the ID/EX output register.
// Only used when PIPE_ID_EX_SKID_EN is defined.
//
// state | meaning
// PASS  | skid empty; incoming beats go straight to the output register
// HOLD  | skid holds one beat parked while the output was stalled
module pipe_skid_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  id_ex_ctrl_t in_ctrl,
  input  id_ex_data_t in_data,
  input  logic        drain,
  output logic        in_ready,
  output logic        load_out,
  output id_ex_ctrl_t ld_ctrl,
  output id_ex_data_t ld_data
);

  typedef enum logic {PASS = 1'b0, HOLD = 1'b1} skid_state_t;

  skid_state_t state_q, state_d;
  id_ex_ctrl_t skid_ctrl_q;
  id_ex_data_t skid_data_q;
  logic        skid_load;
  logic        accept;

  // in_ready comes from the state register only, so out_ready never reaches it
  assign in_ready = (state_q == PASS);
  assign accept   = in_valid && in_ready && !flush;

  // Next-state and load selection
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    skid_load = 1'b0;
    ld_ctrl   = in_ctrl;
    ld_data   = in_data;
    case (state_q)
      PASS: begin
        if (accept) begin
          if (drain) begin
            load_out = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        ld_ctrl = skid_ctrl_q;
        ld_data = skid_data_q;
        if (drain && !flush) begin
          load_out = 1'b1;
          state_d  = PASS;
        end
      end
      default: state_d = PASS;
    endcase
    if (flush) state_d = PASS;
  end

  // State register and skid storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PASS;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else if (skid_load) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, branch-target
// precompute and a saturating back-pressure counter.
// Define PIPE_ID_EX_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int VLANES  = 3,
  parameter int VELEM_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  id_ex_ctrl_t      in_ctrl,
  input  id_ex_data_t      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output id_ex_ctrl_t      out_ctrl,
  output id_ex_data_t      out_data,
  output logic [XLEN-1:0]  out_br_target,
  output logic [CNT_W-1:0] stall_cnt
);

  // The payload struct widths live in the package; parameters must agree with it
  if (XLEN != XLEN_P || VLANES * VELEM_W != VW_P) begin : g_param_check
    $error("pipe_id_ex_stage parameters disagree with pipe_pkg widths");
  end

  logic              out_valid_q;
  id_ex_ctrl_t       ctrl_q;
  id_ex_data_t       data_q;
  logic [XLEN-1:0]   br_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              drain;
  logic              load_out;
  id_ex_ctrl_t       ld_ctrl;
  id_ex_data_t       ld_data;
  logic [XLEN_P-1:0] br_sum;

  // Output register can take a new beat when empty or draining this cycle
  assign drain  = !out_valid_q || out_ready;
  assign br_sum = ld_data.pc + ld_data.sign_imm;

`ifdef PIPE_ID_EX_SKID_EN
  pipe_skid_reg u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .drain    (drain),
    .in_ready (in_ready),
    .load_out (load_out),
    .ld_ctrl  (ld_ctrl),
    .ld_data  (ld_data)
  );
`else
  assign in_ready = drain;
  assign load_out = in_valid && drain && !flush;
  assign ld_ctrl  = in_ctrl;
  assign ld_data  = in_data;
`endif

  // Output register: reset, then flush, then load, then drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      br_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= ld_ctrl;
      data_q      <= ld_data;
      br_q        <= br_sum;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Back-pressure counter: saturates, survives flush, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_ctrl      = out_valid_q ? ctrl_q : '0;
  assign out_data      = data_q;
  assign out_br_target = br_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_id_ex_stage.sv
// Directed bench for pipe_id_ex_stage with a scoreboard of expected beats.
module tb_pipe_id_ex_stage;
  import pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  typedef struct packed {
    id_ex_ctrl_t       c;
    id_ex_data_t       d;
    logic [XLEN-1:0]   br;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  id_ex_ctrl_t      in_ctrl = '0;
  id_ex_data_t      in_data = '0;
  logic             in_ready;
  logic             out_valid;
  id_ex_ctrl_t      out_ctrl;
  id_ex_data_t      out_data;
  logic [XLEN-1:0]  out_br_target;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_id_ex_stage #(.XLEN(32), .VLANES(3), .VELEM_W(16), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .in_data       (in_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_data      (out_data),
    .out_br_target (out_br_target),
    .stall_cnt     (stall_cnt)
  );

  int   nvec = 0;
  int   nerr = 0;
  int   pops = 0;
  exp_t sb[$];
  logic last_in_fire;
  logic last_in_ready;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic id_ex_data_t mk_data(input logic [31:0] pc, input logic [31:0] imm);
    id_ex_data_t d;
    d.pc       = pc;
    d.sign_imm = imm;
    d.rd1      = $urandom;
    d.rd2      = $urandom;
    d.rd       = 5'($urandom);
    d.vd       = 5'($urandom);
    d.rd1v     = 48'({$urandom, $urandom});
    d.rd2v     = 48'({$urandom, $urandom});
    return d;
  endfunction

  function automatic id_ex_ctrl_t mk_ctrl();
    id_ex_ctrl_t c;
    c = id_ex_ctrl_t'(11'($urandom));
    return c;
  endfunction

  // One clock: settle inputs, score handshakes, advance past the edge
  task automatic cycle();
    exp_t e;
    logic in_fire, out_fire;
    #1;
    in_fire       = in_valid && in_ready && !flush && !rst;
    out_fire      = out_valid && out_ready && !rst;
    last_in_ready = in_ready;
    if (out_fire) begin
      nvec++;
      assert (sb.size() != 0) else begin
        nerr++;
        $error("FAIL sb_spurious: observed beat pc %0h expected no beat", out_data.pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_ctrl", out_ctrl, e.c);
        chk("sb_data", out_data, e.d);
        chk("sb_br", out_br_target, e.br);
      end
      pops++;
    end
    if (rst || flush) sb.delete();
    if (in_fire) begin
      e.c  = in_ctrl;
      e.d  = in_data;
      e.br = in_data.pc + in_data.sign_imm;
      sb.push_back(e);
    end
    last_in_fire = in_fire;
    @(posedge clk);
    #1;
  endtask

  initial begin
    id_ex_data_t dexp;
    id_ex_ctrl_t cexp;
    int          sent;
    int          pops0;
    logic [3:0]  ir_seq;
    logic [5:0]  ordy;
    id_ex_data_t abc[3];
    int          idx;

    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ctrl", out_ctrl, '0);
    chk("rst_data", out_data, '0);
    chk("rst_br", out_br_target, '0);
    chk("rst_stall", stall_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Single beat, 1-cycle latency
    in_valid  = 1'b1;
    in_ctrl   = '0;
    in_ctrl.reg_write = 1'b1;
    in_data   = mk_data(32'h100, 32'h20);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_br", out_br_target, 32'h120);
    chk("basic_regw", out_ctrl.reg_write, 1'b1);
    cycle();
    chk("basic_bubble_valid", out_valid, 1'b0);
    chk("basic_bubble_ctrl", out_ctrl, '0);

    // Branch target wraps modulo 2^32
    in_valid = 1'b1;
    in_ctrl  = mk_ctrl();
    in_data  = mk_data(32'hFFFF_FFF0, 32'h20);
    cycle();
    in_valid = 1'b0;
    chk("wrap_br", out_br_target, 32'h0000_0010);
    cycle();

    // Stall: payload held, counter counts then saturates at 7
    cexp      = mk_ctrl();
    dexp      = mk_data(32'h2000, 32'h44);
    in_valid  = 1'b1;
    in_ctrl   = cexp;
    in_data   = dexp;
    cycle();
    in_valid  = 1'b0;
    in_data   = mk_data(32'h0, 32'h0);
    out_ready = 1'b0;
    chk("stall_start_cnt", stall_cnt, 3'd0);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("stall_hold_data", out_data, dexp);
      chk("stall_hold_br", out_br_target, 32'h2044);
      chk("stall_hold_ctrl", out_ctrl, cexp);
    end
    chk("stall_cnt5", stall_cnt, 3'd5);
    for (int i = 0; i < 5; i++) cycle();
    chk("stall_cnt_sat", stall_cnt, 3'd7);
    out_ready = 1'b1;
    cycle();
    chk("stall_drained", out_valid, 1'b0);
    chk("stall_cnt_kept", stall_cnt, 3'd7);

    // Flush with a held beat and an incoming beat
    in_valid  = 1'b1;
    in_ctrl   = mk_ctrl();
    in_data   = mk_data(32'h3000, 32'h8);
    out_ready = 1'b0;
    cycle();
    chk("flush_pre_valid", out_valid, 1'b1);
    in_ctrl   = mk_ctrl();
    in_data   = mk_data(32'h4000, 32'hC);
    flush     = 1'b1;
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", out_ctrl, '0);
    chk("flush_keeps_stall", stall_cnt, 3'd7);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_no_ghost", out_valid, 1'b0);
    end

    // Randomised stream against the scoreboard
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst2_stall", stall_cnt, '0);
    pops0 = pops;
    sent  = 0;
    in_ctrl = mk_ctrl();
    in_data = mk_data($urandom, $urandom);
    for (int t = 0; t < 400 && sent < 24; t++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      cycle();
      if (last_in_fire) begin
        sent++;
        in_ctrl = mk_ctrl();
        in_data = mk_data($urandom, $urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && (sb.size() != 0 || out_valid); t++) cycle();
    chk("stream_sent", sent, 24);
    chk("stream_drained", sb.size(), 0);
    chk("stream_pops", pops - pops0, sent);

    // A,B,C with out_ready low for one cycle
    pops0 = pops;
    ordy  = 6'b111101;
    for (int k = 0; k < 3; k++) abc[k] = mk_data(32'h5000 + 32'(k * 16), 32'(k + 1));
    idx = 0;
    ir_seq = '0;
    for (int t = 0; t < 6; t++) begin
      in_valid  = (idx < 3);
      in_ctrl   = id_ex_ctrl_t'(11'(idx + 1));
      in_data   = abc[idx < 3 ? idx : 2];
      out_ready = ordy[t];
      cycle();
      if (t < 4) ir_seq[t] = last_in_ready;
      if (last_in_fire) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 4 && sb.size() != 0; t++) cycle();
    chk("abc_pops", pops - pops0, 3);
    chk("abc_sb_empty", sb.size(), 0);
`ifdef PIPE_ID_EX_SKID_EN
    chk("abc_in_ready", ir_seq, 4'b1011);
`else
    chk("abc_in_ready", ir_seq, 4'b1101);
`endif

    // Reset mid-stream while a beat is held and another is offered
    in_valid  = 1'b1;
    in_ctrl   = mk_ctrl();
    in_data   = mk_data(32'h6000, 32'h4);
    out_ready = 1'b0;
    cycle();
    cycle();
    chk("midrst_pre_valid", out_valid, 1'b1);
    in_data   = mk_data(32'h7000, 32'h4);
    out_ready = 1'b1;
    rst       = 1'b1;
    cycle();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ctrl", out_ctrl, '0);
    chk("midrst_data", out_data, '0);
    chk("midrst_br", out_br_target, '0);
    chk("midrst_stall", stall_cnt, '0);
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("midrst_lost", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_id_ex_stage.md
PIPE_ID_EX_STAGE -- requirements
Module: pipe_id_ex_stage

Interface
REQ-001 Parameter XLEN, 32, scalar datapath and PC width.
REQ-002 Parameter VLANES, 3, vector lanes per vector operand.
REQ-003 Parameter VELEM_W, 16, bits per vector lane; vector operand width VW = VLANES*VELEM_W.
REQ-004 Parameter CNT_W, 16, stall-counter width.
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 in_valid  in  1  decode stage offers a beat.
REQ-008 in_ready  out  1  stage accepts the beat this cycle.
REQ-009 in_ctrl  in  id_ex_ctrl_t  mem_write, alu_src, reg_write, mem_to_reg[1:0], alu_control[4:0].
REQ-010 in_data  in  id_ex_data_t  pc, rd1, rd2, sign_imm (XLEN each); rd, vd (5 each); rd1v, rd2v (VW each).
REQ-011 flush  in  1  kill all held and incoming beats.
REQ-012 out_valid  out  1  execute-side beat present.
REQ-013 out_ready  in  1  execute stage consumes the beat.
REQ-014 out_ctrl  out  id_ex_ctrl_t  registered control.
REQ-015 out_data  out  id_ex_data_t  registered payload.
REQ-016 out_br_target  out  XLEN  registered pc + sign_imm.
REQ-017 stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-018 A beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-019 Latency in->out is exactly 1 cycle when the output register is empty or drained the same cycle.
REQ-020 out_br_target SHALL equal (in_data.pc + in_data.sign_imm) mod 2^XLEN, registered with the same beat.
REQ-021 out_ctrl SHALL be forced to all-zero whenever out_valid=0, so bubbles never write registers or memory.
REQ-022 out_data and out_br_target SHALL hold their value while out_valid && !out_ready.
REQ-023 flush SHALL clear out_valid (and any skid entry) on the next edge; a beat offered in the flush cycle is dropped, and flush overrides acceptance.
REQ-024 stall_cnt SHALL increment each cycle out_valid && !out_ready, saturate at 2^CNT_W-1 and never wrap.
REQ-025 flush SHALL NOT clear stall_cnt.

Reset
REQ-026 On rst: out_valid=0, out_ctrl=0, out_data=0, out_br_target=0, stall_cnt=0, skid empty, FSM=PASS.
REQ-027 rst takes priority over flush and over any handshake in the same cycle; a beat in flight at reset is lost.

Configuration
REQ-028 Macro PIPE_ID_EX_SKID_EN compiles in a one-entry skid buffer.
REQ-029 With PIPE_ID_EX_SKID_EN: in_ready = !skid_full (registered, no combinational path from out_ready). FSM PASS->HOLD when a beat arrives while the output is stalled. HOLD->PASS when the output drains, with the skid moving to the output. Throughput is 1 beat/cycle under continuous ready.
REQ-030 Without PIPE_ID_EX_SKID_EN: no skid storage; in_ready = !out_valid || out_ready (combinational); the FSM is absent.

Structure
REQ-031 Package pipe_pkg SHALL hold id_ex_ctrl_t, id_ex_data_t, the ALU-control width constant (5) and the register-index width constant (5).
REQ-032 The skid logic SHALL be a sub-module pipe_skid_reg, instantiated only under PIPE_ID_EX_SKID_EN.

Verification
REQ-033 Reset, then one beat with pc=0x100, sign_imm=0x20, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_br_target=0x120, out_ctrl.reg_write=1.
REQ-034 Wrap: pc=0xFFFFFFF0, sign_imm=0x20 -> out_br_target=0x00000010.
REQ-035 Hold out_ready=0 for 5 cycles with out_valid=1 -> payload stable, stall_cnt=5. With CNT_W=3 and 10 cycles -> stall_cnt=7.
REQ-036 Flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, and the input beat never appears.
REQ-037 SKID_EN: out_ready low for 1 cycle during a back-to-back stream of beats A,B,C -> output order is A,B,C with no loss or duplication, and in_ready drops exactly 1 cycle.
REQ-038 Assert rst mid-stream with out_valid=1 -> next edge all outputs are zero.
